// File: rtl/sonar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sonar_pkg                                                     |
// | Purpose  : Shared types and default 50 MHz timing constants for the       |
// |            sonar scan scheduler.                                         |
// | Contents : sonar_state_t - scheduler FSM states (3-bit encoding)         |
// |            c_TRIG_CYCLES, c_GAP_CYCLES, c_TIMEOUT_CYCLES                  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sonar_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      GAP       = 3'd4
   } sonar_state_t;

   // 50 MHz clk: 10 us trigger, 50 ms quiet gap, 38 ms echo limit
   localparam int c_TRIG_CYCLES    = 500;
   localparam int c_GAP_CYCLES     = 2500000;
   localparam int c_TIMEOUT_CYCLES = 1900000;

endpackage
`default_nettype wire

// File: rtl/sonar_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sonar_rr_pick                                                 |
// | Purpose  : Combinational round-robin pick: first masked-in index after    |
// |            'last', wrapping around (last itself is checked last).        |
// | Ports    : mask [NUM_SENSORS] in  - participating sensors                 |
// |            last [ID_W]        in  - previously serviced sensor           |
// |            sel  [ID_W]        out - chosen sensor (0 when any=0)         |
// |            any                out - at least one mask bit set            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sonar_rr_pick #(
   parameter int NUM_SENSORS = 4,
   parameter int ID_W        = $clog2(NUM_SENSORS)
) (
   input  logic [NUM_SENSORS-1:0] mask,
   input  logic [ID_W-1:0]        last,
   output logic [ID_W-1:0]        sel,
   output logic                   any
);

   always_comb begin
      int w_idx;
      sel   = '0;
      any   = 1'b0;
      w_idx = 0;
      for (int i = 1; i <= NUM_SENSORS; i++) begin
         w_idx = (int'(last) + i) % NUM_SENSORS;
         if (!any && mask[w_idx]) begin
            any = 1'b1;
            sel = ID_W'(w_idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sonar_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sonar_scan_scheduler                                          |
// | Purpose  : Time-shares one echo timer among NUM_SENSORS ultrasonic        |
// |            rangefinders: round-robin trigger, echo width measurement,    |
// |            timeout detection and a quiet gap after every measurement.    |
// | Ports    : clk, rst_n (async, active-low)                                 |
// |            enable, sensor_mask[N], echo_in[N]          - inputs           |
// |            trig_out[N], busy                           - control outputs  |
// |            result_valid, result_id, result_cycles,                       |
// |            result_timeout                              - result outputs   |
// | Option   : `define SONAR_RESULT_BANK_EN adds rd_id / rd_cycles /          |
// |            rd_timeout / rd_fresh per-sensor result bank.                 |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sonar_scan_scheduler
   import sonar_pkg::*;
#(
   parameter int NUM_SENSORS    = 4,
   parameter int TRIG_CYCLES    = c_TRIG_CYCLES,
   parameter int GAP_CYCLES     = c_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES,
   parameter int CNT_W          = 32,
   parameter int ID_W           = $clog2(NUM_SENSORS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] sensor_mask,
   input  logic [NUM_SENSORS-1:0] echo_in,
`ifdef SONAR_RESULT_BANK_EN
   input  logic [ID_W-1:0]        rd_id,
   output logic [CNT_W-1:0]       rd_cycles,
   output logic                   rd_timeout,
   output logic                   rd_fresh,
`endif
   output logic [NUM_SENSORS-1:0] trig_out,
   output logic                   busy,
   output logic                   result_valid,
   output logic [ID_W-1:0]        result_id,
   output logic [CNT_W-1:0]       result_cycles,
   output logic                   result_timeout
);

   localparam logic [CNT_W-1:0]       c_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]       c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]       c_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]       c_TO_FULL   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [NUM_SENSORS-1:0] c_ONE       = NUM_SENSORS'(1);

   logic [NUM_SENSORS-1:0] r_sync1;
   logic [NUM_SENSORS-1:0] r_sync2;
   sonar_state_t           r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [ID_W-1:0]        r_sel;
   logic [ID_W-1:0]        r_last;
   logic                   r_prev_echo;
   logic [ID_W-1:0]        w_pick;
   logic                   w_any;
   logic                   w_echo_s;

   // Two-flop synchronizer per raw echo line
   generate
      for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync1[g] <= 1'b0;
               r_sync2[g] <= 1'b0;
            end else begin
               r_sync1[g] <= echo_in[g];
               r_sync2[g] <= r_sync1[g];
            end
         end
      end
   endgenerate

   assign w_echo_s = r_sync2[r_sel];
   assign busy     = (r_state != IDLE);

   sonar_rr_pick #(
      .NUM_SENSORS (NUM_SENSORS),
      .ID_W        (ID_W)
   ) u_rr_pick (
      .mask (sensor_mask),
      .last (r_last),
      .sel  (w_pick),
      .any  (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_sel          <= '0;
         r_last         <= ID_W'(NUM_SENSORS - 1);
         r_prev_echo    <= 1'b0;
         trig_out       <= '0;
         result_valid   <= 1'b0;
         result_id      <= '0;
         result_cycles  <= '0;
         result_timeout <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               // Mask and enable are only looked at here, so a started
               // measurement always runs to the end of its gap.
               if (enable && w_any) begin
                  r_sel    <= w_pick;
                  r_cnt    <= '0;
                  trig_out <= c_ONE << w_pick;
                  r_state  <= TRIG;
               end
            end
            TRIG: begin
               if (r_cnt == c_TRIG_LAST) begin
                  trig_out    <= '0;
                  r_cnt       <= '0;
                  r_prev_echo <= w_echo_s;
                  r_state     <= WAIT_RISE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_RISE: begin
               // Edge detect: an echo that is already high must fall first
               r_prev_echo <= w_echo_s;
               if (w_echo_s && !r_prev_echo) begin
                  r_cnt   <= CNT_W'(1);
                  r_state <= MEASURE;
               end else if (r_cnt == c_TO_LAST) begin
                  result_valid   <= 1'b1;
                  result_id      <= r_sel;
                  result_cycles  <= '0;
                  result_timeout <= 1'b1;
                  r_cnt          <= '0;
                  r_state        <= GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            MEASURE: begin
               if (!w_echo_s) begin
                  result_valid   <= 1'b1;
                  result_id      <= r_sel;
                  result_cycles  <= r_cnt;
                  result_timeout <= 1'b0;
                  r_cnt          <= '0;
                  r_state        <= GAP;
               end else if (r_cnt == c_TO_FULL) begin
                  result_valid   <= 1'b1;
                  result_id      <= r_sel;
                  result_cycles  <= r_cnt;
                  result_timeout <= 1'b1;
                  r_cnt          <= '0;
                  r_state        <= GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            GAP: begin
               if (r_cnt == c_GAP_LAST) begin
                  r_last  <= r_sel;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               trig_out <= '0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

`ifdef SONAR_RESULT_BANK_EN
   logic [CNT_W-1:0]       r_bank_cycles [NUM_SENSORS];
   logic [NUM_SENSORS-1:0] r_bank_to;
   logic [NUM_SENSORS-1:0] r_bank_fresh;
   logic [ID_W-1:0]        r_rd_id_q;
   logic                   w_rd_ok;

   assign w_rd_ok = (int'(rd_id) < NUM_SENSORS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SENSORS; i++) begin
            r_bank_cycles[i] <= '0;
         end
         r_bank_to    <= '0;
         r_bank_fresh <= '0;
         r_rd_id_q    <= '0;
      end else begin
         r_rd_id_q <= rd_id;
         // A read counts once rd_id has been held for a full cycle
         if (w_rd_ok && (rd_id == r_rd_id_q)) begin
            r_bank_fresh[rd_id] <= 1'b0;
         end
         // New result wins over a same-cycle read clear
         if (result_valid) begin
            r_bank_cycles[result_id] <= result_cycles;
            r_bank_to[result_id]     <= result_timeout;
            r_bank_fresh[result_id]  <= 1'b1;
         end
      end
   end

   assign rd_cycles  = w_rd_ok ? r_bank_cycles[rd_id] : '0;
   assign rd_timeout = w_rd_ok ? r_bank_to[rd_id]     : 1'b0;
   assign rd_fresh   = w_rd_ok ? r_bank_fresh[rd_id]  : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sonar_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sonar_scan_scheduler                                       |
// | Purpose  : Directed self-checking bench for sonar_scan_scheduler with     |
// |            NUM_SENSORS=4, TRIG_CYCLES=5, GAP_CYCLES=20,                  |
// |            TIMEOUT_CYCLES=100. Bank checks build with                     |
// |            SONAR_RESULT_BANK_EN.                                          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sonar_scan_scheduler;

   localparam int N  = 4;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [N-1:0]  sensor_mask;
   logic [N-1:0]  echo_in;
   logic [N-1:0]  trig_out;
   logic          busy;
   logic          result_valid;
   logic [1:0]    result_id;
   logic [CW-1:0] result_cycles;
   logic          result_timeout;
`ifdef SONAR_RESULT_BANK_EN
   logic [1:0]    rd_id;
   logic [CW-1:0] rd_cycles;
   logic          rd_timeout;
   logic          rd_fresh;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sonar_scan_scheduler #(
      .NUM_SENSORS    (N),
      .TRIG_CYCLES    (5),
      .GAP_CYCLES     (20),
      .TIMEOUT_CYCLES (100),
      .CNT_W          (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .sensor_mask    (sensor_mask),
      .echo_in        (echo_in),
`ifdef SONAR_RESULT_BANK_EN
      .rd_id          (rd_id),
      .rd_cycles      (rd_cycles),
      .rd_timeout     (rd_timeout),
      .rd_fresh       (rd_fresh),
`endif
      .trig_out       (trig_out),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_id      (result_id),
      .result_cycles  (result_cycles),
      .result_timeout (result_timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded waits: n = ticks taken, found = event seen within the limit
   task automatic wait_trig(input int limit, output logic found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < limit) begin
         tick();
         n++;
         if (trig_out != '0) found = 1'b1;
      end
   endtask

   task automatic wait_trig_low(input int limit, output logic found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < limit) begin
         tick();
         n++;
         if (trig_out == '0) found = 1'b1;
      end
   endtask

   task automatic wait_result(input int limit, output logic found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < limit) begin
         tick();
         n++;
         if (result_valid) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; sensor_mask = '0; echo_in = '0;
`ifdef SONAR_RESULT_BANK_EN
      rd_id = '0;
`endif
      repeat (3) tick();
      checks++; if (trig_out !== 4'b0000) begin failures++; $display("FAIL reset_trig: got %b expected 0000", trig_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
      checks++; if (result_id !== 2'd0 || result_cycles !== 32'd0 || result_timeout !== 1'b0) begin
         failures++; $display("FAIL reset_result: got id=%0d cyc=%0d to=%b expected 0/0/0", result_id, result_cycles, result_timeout);
      end
   endtask

   // Sensor 0 measured, sensor 1 no echo, sensor 2 echo stuck, sensor 3 too long
   task automatic test_basic_and_timeouts();
      logic f; int n;
      enable = 1'b1; sensor_mask = 4'b1111; rst_n = 1'b1;
      wait_trig(10, f, n);
      checks++; if (!f || trig_out !== 4'b0001) begin failures++; $display("FAIL basic_trig0: got %b expected 0001", trig_out); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
      wait_trig_low(20, f, n);
      checks++; if (!f || n != 5) begin failures++; $display("FAIL basic_trig_len: got %0d expected 5", n); end
      repeat (9) tick();
      echo_in[0] = 1'b1;
      repeat (37) tick();
      echo_in[0] = 1'b0;
      wait_result(20, f, n);
      checks++; if (!f || result_id !== 2'd0 || result_cycles !== 32'd37 || result_timeout !== 1'b0) begin
         failures++; $display("FAIL basic_result: got v=%b id=%0d cyc=%0d to=%b expected 1/0/37/0", f, result_id, result_cycles, result_timeout);
      end
      tick();
      checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL basic_strobe: got %b expected 0", result_valid); end
      wait_trig(60, f, n);
      checks++; if (!f || n != 20 || trig_out !== 4'b0010) begin failures++; $display("FAIL basic_gap_next: got n=%0d trig=%b expected n=20 trig=0010", n, trig_out); end

      // Sensor 1: no echo at all
      wait_trig_low(20, f, n);
      checks++; if (!f || n != 5) begin failures++; $display("FAIL noecho_trig_len: got %0d expected 5", n); end
      wait_result(200, f, n);
      checks++; if (!f || n != 100) begin failures++; $display("FAIL noecho_latency: got %0d expected 100", n); end
      checks++; if (result_id !== 2'd1 || result_cycles !== 32'd0 || result_timeout !== 1'b1) begin
         failures++; $display("FAIL noecho_result: got id=%0d cyc=%0d to=%b expected 1/0/1", result_id, result_cycles, result_timeout);
      end
      echo_in[2] = 1'b1;
      wait_trig(60, f, n);
      checks++; if (!f || n != 21 || trig_out !== 4'b0100) begin failures++; $display("FAIL noecho_gap: got n=%0d trig=%b expected n=21 trig=0100", n, trig_out); end

      // Sensor 2: echo high before and through the trigger
      wait_trig_low(20, f, n);
      wait_result(200, f, n);
      checks++; if (!f || n != 100 || result_id !== 2'd2 || result_cycles !== 32'd0 || result_timeout !== 1'b1) begin
         failures++; $display("FAIL stuck_result: got n=%0d id=%0d cyc=%0d to=%b expected 100/2/0/1", n, result_id, result_cycles, result_timeout);
      end
      echo_in[2] = 1'b0;
      wait_trig(60, f, n);
      checks++; if (!f || trig_out !== 4'b1000) begin failures++; $display("FAIL stuck_next: got %b expected 1000", trig_out); end

      // Sensor 3: valid rise, then echo far longer than the limit
      wait_trig_low(20, f, n);
      repeat (3) tick();
      echo_in[3] = 1'b1;
      wait_result(150, f, n);
      checks++; if (!f || result_id !== 2'd3 || result_cycles !== 32'd100 || result_timeout !== 1'b1) begin
         failures++; $display("FAIL long_result: got v=%b id=%0d cyc=%0d to=%b expected 1/3/100/1", f, result_id, result_cycles, result_timeout);
      end
      echo_in[3] = 1'b0;
   endtask

   task automatic test_mask();
      logic f; int n; int id; logic [3:0] exp_t;
      sensor_mask = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         id    = (k % 2 == 0) ? 1 : 3;
         exp_t = (k % 2 == 0) ? 4'b0010 : 4'b1000;
         wait_trig(60, f, n);
         checks++; if (!f || trig_out !== exp_t) begin failures++; $display("FAIL mask_order%0d: got %b expected %b", k, trig_out, exp_t); end
         wait_trig_low(20, f, n);
         repeat (2) tick();
         echo_in[id] = 1'b1;
         repeat (3 + k) tick();
         echo_in[id] = 1'b0;
         wait_result(20, f, n);
         checks++; if (!f || int'(result_id) != id || result_cycles !== 32'(3 + k) || result_timeout !== 1'b0) begin
            failures++; $display("FAIL mask_result%0d: got id=%0d cyc=%0d to=%b expected %0d/%0d/0", k, result_id, result_cycles, result_timeout, id, 3 + k);
         end
      end
   endtask

   task automatic test_enable_drop();
      logic f; int n; logic saw_trig;
      sensor_mask = 4'b1111;
      wait_trig(60, f, n);
      checks++; if (!f || trig_out !== 4'b0001) begin failures++; $display("FAIL drop_trig: got %b expected 0001", trig_out); end
      wait_trig_low(20, f, n);
      repeat (2) tick();
      echo_in[0] = 1'b1;
      repeat (5) tick();
      enable = 1'b0;
      repeat (7) tick();
      echo_in[0] = 1'b0;
      wait_result(20, f, n);
      checks++; if (!f || result_id !== 2'd0 || result_cycles !== 32'd12 || result_timeout !== 1'b0) begin
         failures++; $display("FAIL drop_result: got v=%b id=%0d cyc=%0d to=%b expected 1/0/12/0", f, result_id, result_cycles, result_timeout);
      end
      repeat (19) tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_gap_busy: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
      saw_trig = 1'b0;
      repeat (40) begin
         tick();
         if (trig_out != '0 || busy) saw_trig = 1'b1;
      end
      checks++; if (saw_trig !== 1'b0) begin failures++; $display("FAIL drop_parked: got activity=%b expected 0", saw_trig); end
   endtask

   task automatic test_reset_mid_trig();
      logic f; int n;
      enable = 1'b1;
      wait_trig(10, f, n);
      checks++; if (!f || trig_out !== 4'b0010) begin failures++; $display("FAIL rst_pre_trig: got %b expected 0010", trig_out); end
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (trig_out !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rst_async: got trig=%b busy=%b expected 0000/0", trig_out, busy); end
      checks++; if (result_valid !== 1'b0 || result_id !== 2'd0 || result_cycles !== 32'd0 || result_timeout !== 1'b0) begin
         failures++; $display("FAIL rst_outputs: got v=%b id=%0d cyc=%0d to=%b expected 0/0/0/0", result_valid, result_id, result_cycles, result_timeout);
      end
      tick();
      rst_n = 1'b1;
      wait_trig(10, f, n);
      checks++; if (!f || trig_out !== 4'b0001) begin failures++; $display("FAIL rst_rr_restart: got %b expected 0001", trig_out); end
   endtask

`ifdef SONAR_RESULT_BANK_EN
   // Picks up while sensor 0 trigger is active after test_reset_mid_trig
   task automatic test_bank();
      logic f; int n;
      for (int s = 0; s < 4; s++) begin
         if (s != 0) wait_trig(60, f, n);
         wait_trig_low(20, f, n);
         repeat (2) tick();
         echo_in[s] = 1'b1;
         repeat (10 + s) tick();
         echo_in[s] = 1'b0;
         wait_result(20, f, n);
         checks++; if (!f || int'(result_id) != s) begin failures++; $display("FAIL bank_scan%0d: got id=%0d expected %0d", s, result_id, s); end
      end
      enable = 1'b0;
      tick();
      rd_id = 2'd2;
      tick();
      checks++; if (rd_cycles !== 32'd12 || rd_timeout !== 1'b0 || rd_fresh !== 1'b1) begin
         failures++; $display("FAIL bank_read: got cyc=%0d to=%b fresh=%b expected 12/0/1", rd_cycles, rd_timeout, rd_fresh);
      end
      tick();
      checks++; if (rd_fresh !== 1'b0 || rd_cycles !== 32'd12) begin
         failures++; $display("FAIL bank_reread: got fresh=%b cyc=%0d expected 0/12", rd_fresh, rd_cycles);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_and_timeouts();
      test_mask();
      test_enable_drop();
      test_reset_mid_trig();
`ifdef SONAR_RESULT_BANK_EN
      test_bank();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sonar_scan_scheduler.md
Name: sonar_scan_scheduler

Overview:
- Time-shares one echo-measurement datapath among NUM_SENSORS ultrasonic rangefinders.
- Arbitrates round-robin over enabled sensors and drives the selected sensor's trigger pulse.
- Times its echo width in clk cycles and enforces an inter-measurement quiet gap against cross-talk.
- Sits between the sensor GPIO pins and the distance-processing and display logic.

Parameters:
- NUM_SENSORS, 4, number of sensors; must be ≥2. ID_W = $clog2(NUM_SENSORS).
- TRIG_CYCLES, 500, trigger high time in cycles (10 us at 50 MHz).
- GAP_CYCLES, 2500000, quiet time after every measurement (50 ms).
- TIMEOUT_CYCLES, 1900000, maximum wait for echo rise and maximum echo width (38 ms).
- CNT_W, 32, width of the timing counter and of result_cycles.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; scanning runs while high.
- sensor_mask  in  NUM_SENSORS  1 = sensor participates.
- echo_in  in  NUM_SENSORS  raw asynchronous echo lines.
- trig_out  out  NUM_SENSORS  trigger lines; at most one high at any time.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  single-cycle strobe.
- result_id  out  ID_W  sensor that produced the result.
- result_cycles  out  CNT_W  echo high width in cycles.
- result_timeout  out  1  qualifies result_valid: no echo, or echo too long.

Behaviour:
- Reset: state IDLE; trig_out=0, busy=0, result_valid=0, result_id=0, result_cycles=0, result_timeout=0; RR pointer last=NUM_SENSORS-1; synchronizers cleared.
- echo_in: every bit passes through a 2-FF synchronizer. Only the selected sensor's synced bit (echo_s) is used. Pipeline latency is 2 cycles.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE:
  - If enable and (sensor_mask != 0): sel = first masked-in index after last, with wrap-around. Go to TRIG, cnt=0.
  - sensor_mask is sampled only here; mask changes mid-measurement have no effect.
- TRIG:
  - trig_out[sel]=1 for exactly TRIG_CYCLES cycles; echo is ignored.
  - Then go to WAIT_RISE, cnt=0, prev_echo=echo_s.
- WAIT_RISE:
  - Waits for a 0→1 transition of echo_s. An echo already high on entry must fall first.
  - On rise: go to MEASURE, cnt=1.
  - If cnt reaches TIMEOUT_CYCLES first: emit timeout result with result_cycles=0, go to GAP.
- MEASURE:
  - While echo_s=1, cnt+1.
  - On echo_s=0: result_valid=1 for one cycle, result_cycles=cnt, result_timeout=0, go to GAP.
  - If cnt reaches TIMEOUT_CYCLES while echo is still high: timeout result with result_cycles=TIMEOUT_CYCLES, go to GAP.
- GAP:
  - Counts GAP_CYCLES, then go to IDLE with last=sel.
  - GAP is entered after every result, including timeouts.
- result_id, result_cycles and result_timeout hold their values until the next result.
- enable dropping mid-scan: the current measurement and its GAP complete; the FSM then parks in IDLE. No trigger is ever truncated.
- Single enabled sensor: the same sensor is re-selected every round.
- mask=0 with enable=1: remain in IDLE, busy=0.
- Counter never exceeds TIMEOUT_CYCLES or GAP_CYCLES, so no wrap-around occurs.
- Reset asserted mid-operation: immediate return to reset values; trig_out drops asynchronously.

Optional Feature:
- SONAR_RESULT_BANK_EN defined:
  - Adds input rd_id [ID_W] and outputs rd_cycles [CNT_W], rd_timeout [1], rd_fresh [1].
  - Per-sensor register bank is written at each result_valid.
  - rd_* is a combinational read of entry rd_id.
  - rd_fresh is set on write and cleared the cycle after it is read with rd_id stable for one cycle. All bank entries reset to 0.
- Undefined: no bank, no extra ports; the result_* outputs are the only result path.

Decomposition:
- Package sonar_pkg:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GAP), 3-bit encoding.
  - default timing constants for a 50 MHz clk (TRIG_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES).
- Sub-module sonar_rr_pick:
  - combinational round-robin: inputs mask and last; outputs sel and any.
  - instantiated once.
- The 2-FF synchronizer is generated inline per bit.

Test Plan (bench params: NUM_SENSORS=4, TRIG_CYCLES=5, GAP_CYCLES=20, TIMEOUT_CYCLES=100):
- Reset, enable=1, mask=4'b1111; sensor 0 echo rises 10 cycles after trig falls and stays high 37 cycles → trig_out=4'b0001 for exactly 5 cycles; result_valid with id=0, cycles=37, timeout=0; next trig_out=4'b0010 after 20 quiet cycles.
- mask=4'b1010, full scan → trigger order 1,3,1,3; sensors 0 and 2 are never triggered.
- Sensor echo never rises → result_valid 100 cycles after the trigger ends with timeout=1, cycles=0; the gap is still observed.
- Echo stuck high through the trigger → no rise detected, timeout=1 result. Echo high 150 cycles after a valid rise → timeout=1, cycles=100.
- enable deasserted during MEASURE → result delivered, GAP completes, busy=0, no further triggers. Reset asserted mid-TRIG → trig_out=0 the same cycle and all outputs at reset values.
- SONAR_RESULT_BANK_EN: after a scan of all 4 sensors, reading rd_id=2 returns sensor 2's cycles with rd_fresh=1; rd_fresh=0 on the following read.
